// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile -- 31-entry, 2-read / 1-write register file with a hard-wired zero
// register (XZR) at address 31.
//
// Ports
//   clk    in   1   single clock; all state updates on its rising edge
//   reset  in   1   synchronous, active-high; loads the reset image
//   we3    in   1   write enable for write port 3
//   ra1    in   5   read address, port 1 (ALU operand a)
//   ra2    in   5   read address, port 2 (ALU operand b / store data)
//   wa3    in   5   write address
//   wd3    in   N   write data
//   rd1    out  N   read data for ra1 (combinational)
//   rd2    out  N   read data for ra2 (combinational)
//
// Parameters
//   N            data width of every register and data port
//   RESET_INDEX  1: entry i resets to i; 0: every entry resets to 0
//
// Optional feature
//   REGFILE_BYPASS_EN  when defined, a read of the address being written in
//                      the same cycle returns wd3 (write-through). When
//                      undefined, the old value is returned until the edge.
//
// Reads are zero-latency by design: the datapath reads operands and writes
// back results within a single cycle, so rd1/rd2 cannot be registered.
// ----------------------------------------------------------------------------
module regfile #(
    parameter int N           = 64,
    parameter int RESET_INDEX = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we3,
    input  logic [4:0]   ra1,
    input  logic [4:0]   ra2,
    input  logic [4:0]   wa3,
    input  logic [N-1:0] wd3,
    output logic [N-1:0] rd1,
    output logic [N-1:0] rd2
);

    localparam logic [4:0] XZR_ADDR = 5'd31;

    // X0..X30 only; XZR has no storage behind it.
    logic [N-1:0] regs_r [0:30];

    // A write is only meaningful outside reset and away from XZR.
    logic write_hit_s;

    // Qualify the write strobe once so storage and bypass agree on it.
    always_comb begin
        write_hit_s = 1'b0;
        if (we3 && !reset && (wa3 != XZR_ADDR)) begin
            write_hit_s = 1'b1;
        end else begin
            write_hit_s = 1'b0;
        end
    end

    // Storage update: reset image has priority over any write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 31; i++) begin
                if (RESET_INDEX != 0) begin
                    regs_r[i] <= N'(i);
                end else begin
                    regs_r[i] <= '0;
                end
            end
        end else if (write_hit_s) begin
            regs_r[wa3] <= wd3;
        end
    end

    // Read port 1: XZR reads zero, optional same-cycle write-through.
    always_comb begin
        rd1 = '0;
        if (ra1 == XZR_ADDR) begin
            rd1 = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (write_hit_s && (ra1 == wa3)) begin
            rd1 = wd3;
`endif
        end else begin
            rd1 = regs_r[ra1];
        end
    end

    // Read port 2: independent copy of the port 1 logic.
    always_comb begin
        rd2 = '0;
        if (ra2 == XZR_ADDR) begin
            rd2 = '0;
`ifdef REGFILE_BYPASS_EN
        end else if (write_hit_s && (ra2 == wa3)) begin
            rd2 = wd3;
`endif
        end else begin
            rd2 = regs_r[ra2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// ----------------------------------------------------------------------------
// tb_regfile -- self-checking bench for regfile (N=64, RESET_INDEX=1).
// Inputs change just after the falling edge; reads are checked 1 time unit
// later, well away from the rising edge where state updates.
// ----------------------------------------------------------------------------
module tb_regfile;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [63:0] rd1;
    logic [63:0] rd2;

    int checks = 0;
    int errors = 0;

    // Reference contents of X0..X30, plus whether a reset has ever happened.
    logic [63:0] mdl [0:30];
    bit          mdl_valid = 1'b0;

    regfile #(.N(64), .RESET_INDEX(1)) dut (
        .clk   (clk),
        .reset (reset),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // 10-unit clock, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value for address a given the current input drive.
    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (we3 && !reset && wa3 != 5'd31 && a == wa3) return wd3;
`endif
        return mdl[a];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One rising edge; the model applies the same rules to the held inputs.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 31; i++) mdl[i] = 64'(i);
            mdl_valid = 1'b1;
        end else if (we3 && wa3 != 5'd31) begin
            mdl[wa3] = wd3;
        end
        @(negedge clk);
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        ra1 = a1;
        ra2 = a2;
        #1;
        chk({tag, "_rd1"}, rd1, exp_rd(a1));
        chk({tag, "_rd2"}, rd2, exp_rd(a2));
    endtask

    // Read every address on both ports (port 2 walks in reverse).
    task automatic sweep(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i), tag);
        end
    endtask

    initial begin
        logic [63:0] neg_val;
        neg_val = -64'd3781;

        // Pre-reset: XZR reads zero even with storage undefined; reset and
        // write requested together on the first edge.
        reset = 1'b1; we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
        ra1 = 5'd31; ra2 = 5'd31;
        #1;
        chk("prereset_xzr_rd1", rd1, 64'd0);
        chk("prereset_xzr_rd2", rd2, 64'd0);
        @(negedge clk);
        tick();

        // Reset image
        reset = 1'b0; we3 = 1'b0;
        ra1 = 5'd5; ra2 = 5'd30; #1;
        chk("rst_x5", rd1, 64'd5);
        chk("rst_x30", rd2, 64'd30);
        ra1 = 5'd31; #1;
        chk("rst_xzr", rd1, 64'd0);
        ra1 = 5'd7; #1;
        chk("rst_beats_write_x7", rd1, 64'd7);
        sweep("rst_sweep");

        // Negative value round-trip, neighbour untouched
        we3 = 1'b1; wa3 = 5'd3; wd3 = neg_val;
        tick();
        we3 = 1'b0;
        ra1 = 5'd3; ra2 = 5'd4; #1;
        chk("neg_x3", rd1, neg_val);
        chk("hold_x4", rd2, 64'd4);

        // Write to XZR is discarded
        we3 = 1'b1; wa3 = 5'd31; wd3 = 64'd1206;
        ra2 = 5'd31; #1;
        chk("xzr_write_same_cycle", rd2, 64'd0);
        tick();
        we3 = 1'b0;
        sweep("xzr_write_sweep");

        // we3=0 holds
        we3 = 1'b0; wa3 = 5'd2; wd3 = 64'd52;
        tick();
        ra1 = 5'd2; #1;
        chk("we0_x2", rd1, 64'd2);

        // Same-cycle read/write of one address
        we3 = 1'b1; wa3 = 5'd9; wd3 = 64'd4404;
        ra1 = 5'd9; ra2 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
        chk("rw_same_rd1", rd1, 64'd4404);
        chk("rw_same_rd2", rd2, 64'd4404);
`else
        chk("rw_same_rd1", rd1, 64'd9);
        chk("rw_same_rd2", rd2, 64'd9);
`endif
        tick();
        we3 = 1'b0; #1;
        chk("rw_after_rd1", rd1, 64'd4404);
        chk("rw_after_rd2", rd2, 64'd4404);

        // Mid-sequence reset with a write on the same edge; during reset the
        // ports still show stored contents and never bypass.
        reset = 1'b1; we3 = 1'b1; wa3 = 5'd7; wd3 = 64'hFFFF_FFFF_FFFF_FFFF;
        ra1 = 5'd3; ra2 = 5'd7; #1;
        chk("in_reset_x3_old", rd1, neg_val);
        chk("in_reset_x7_nobypass", rd2, 64'd7);
        tick();
        reset = 1'b0; we3 = 1'b0;
        ra1 = 5'd7; ra2 = 5'd3; #1;
        chk("midrst_x7", rd1, 64'd7);
        chk("midrst_x3", rd2, 64'd3);
        sweep("midrst_sweep");

        // Randomised traffic against the model, reads checked before each edge
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            we3   = ($urandom_range(0, 3) != 0);
            wa3   = 5'($urandom_range(0, 31));
            wd3   = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                ra1 = wa3;
            end else begin
                ra1 = 5'($urandom_range(0, 31));
            end
            ra2 = ($urandom_range(0, 4) == 0) ? ra1 : 5'($urandom_range(0, 31));
            rd(ra1, ra2, "rand");
            tick();
        end
        reset = 1'b0; we3 = 1'b0;
        sweep("final_sweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
